// File: rtl/shift_arbiter_if.sv
// Request, response and shifter-side signals of the shift arbiter, grouped so
// the arbiter and its environment connect through a single port.
interface shift_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_op0;
  logic [2:0]  req_op1;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [4:0]  req_amt0;
  logic [4:0]  req_amt1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic [2:0]  sh_op;
  logic [31:0] sh_a;
  logic [4:0]  sh_amt;
  logic [31:0] sh_result;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_amt0, req_amt1,
    input  resp_ready, sh_result,
    output req_ready, resp_valid, resp_data, sh_op, sh_a, sh_amt
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_amt0, req_amt1,
    output resp_ready, sh_result,
    input  req_ready, resp_valid, resp_data, sh_op, sh_a, sh_amt
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational shifter between the execute
// stage (port 0) and the debug port (port 1), with a settle-time counter.
module shift_arbiter #(
  parameter int unsigned SH_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  shift_arbiter_if.slave  bus,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SH_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        owner;
  logic        grant;
  logic        accept;
  logic        capture;
  logic [3:0]  cnt;

  // A lone requester always wins; on a tie the port not served last wins.
  always_comb begin
    grant = bus.req_valid[1];
    if (bus.req_valid == 2'b11) begin
      grant = ~last_grant;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 2'b00;
    bus.resp_valid = 2'b00;
    accept         = 1'b0;
    capture        = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        bus.req_ready = grant ? {bus.req_valid[1], 1'b0} : {1'b0, bus.req_valid[0]};
        accept        = |bus.req_ready;
        if (accept) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = owner ? 2'b10 : 2'b01;
        if (bus.resp_ready[owner]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // last_grant resets to 1 so port 0 takes the first tie after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.sh_op     <= 3'd0;
      bus.sh_a      <= 32'd0;
      bus.sh_amt    <= 5'd0;
      bus.resp_data <= 32'd0;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      cnt           <= 4'd0;
    end else if (accept) begin
      bus.sh_op  <= grant ? bus.req_op1  : bus.req_op0;
      bus.sh_a   <= grant ? bus.req_a1   : bus.req_a0;
      bus.sh_amt <= grant ? bus.req_amt1 : bus.req_amt0;
      last_grant <= grant;
      owner      <= grant;
      cnt        <= CNT_INIT;
    end else if (capture) begin
      bus.resp_data <= bus.sh_result;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a transaction-level model checks the SH_LAT=1
// instance every cycle; SH_LAT=4 and SH_LAT=3 instances get directed checks.
module tb_shift_arbiter;

  localparam int unsigned LAT_A = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic busy_a, busy_b, busy_c;
  int n_checks = 0;
  int n_fail   = 0;
  int unsigned edge_cnt = 0;

  shift_arbiter_if ifa ();
  shift_arbiter_if ifb ();
  shift_arbiter_if ifc ();

  shift_arbiter #(.SH_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave), .busy(busy_a));
  shift_arbiter #(.SH_LAT(4))     dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave), .busy(busy_b));
  shift_arbiter #(.SH_LAT(3))     dut_c (.clk(clk), .rst(rst_c), .bus(ifc.slave), .busy(busy_c));

  function automatic logic [31:0] shift_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [4:0] amt);
    logic [31:0] r;
    case (op)
      3'b011:  r = a << amt;
      3'b100:  r = a >> amt;
      3'b101:  r = $signed(a) >>> amt;
      default: r = a;
    endcase
    return r;
  endfunction

  assign ifa.sh_result = shift_fn(ifa.sh_op, ifa.sh_a, ifa.sh_amt);
  assign ifb.sh_result = shift_fn(ifb.sh_op, ifb.sh_a, ifb.sh_amt);
  assign ifc.sh_result = shift_fn(ifc.sh_op, ifc.sh_a, ifc.sh_amt);

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Transaction model of instance A: who owns the shifter, when its answer is due.
  int          m_owner = -1;
  int          m_last  = 1;
  logic [2:0]  m_op    = '0;
  logic [31:0] m_a     = '0;
  logic [4:0]  m_amt   = '0;
  logic [31:0] m_data  = '0;
  logic [31:0] m_exp   = '0;
  int unsigned m_resp_edge = 0;

  always @(negedge clk) begin
    logic [1:0] e_ready;
    logic [1:0] e_rvalid;
    int g;
    if (!rst_a) begin
      m_owner = -1; m_last = 1; m_op = '0; m_a = '0; m_amt = '0; m_data = '0;
      check_output("rst busy", busy_a, 0);
      check_output("rst resp_valid", ifa.resp_valid, 0);
      check_output("rst sh_a", ifa.sh_a, 0);
      check_output("rst sh_op", ifa.sh_op, 0);
      check_output("rst sh_amt", ifa.sh_amt, 0);
      check_output("rst resp_data", ifa.resp_data, 0);
    end else begin
      if (m_owner >= 0 && edge_cnt == m_resp_edge) m_data = m_exp;
      e_ready  = 2'b00;
      e_rvalid = 2'b00;
      g = 0;
      if (m_owner < 0) begin
        if (ifa.req_valid == 2'b11) g = (m_last == 1) ? 0 : 1;
        else                        g = ifa.req_valid[1] ? 1 : 0;
        if (ifa.req_valid != 2'b00) e_ready[g] = 1'b1;
      end else if (edge_cnt >= m_resp_edge) begin
        e_rvalid[m_owner] = 1'b1;
      end
      check_output("model req_ready", ifa.req_ready, e_ready);
      check_output("model resp_valid", ifa.resp_valid, e_rvalid);
      check_output("model busy", busy_a, (m_owner >= 0) ? 1 : 0);
      check_output("model sh_op", ifa.sh_op, m_op);
      check_output("model sh_a", ifa.sh_a, m_a);
      check_output("model sh_amt", ifa.sh_amt, m_amt);
      check_output("model resp_data", ifa.resp_data, m_data);
      if (e_ready != 2'b00) begin
        m_owner = g;
        m_last  = g;
        m_op    = (g == 1) ? ifa.req_op1  : ifa.req_op0;
        m_a     = (g == 1) ? ifa.req_a1   : ifa.req_a0;
        m_amt   = (g == 1) ? ifa.req_amt1 : ifa.req_amt0;
        m_exp   = shift_fn(m_op, m_a, m_amt);
        m_resp_edge = edge_cnt + 1 + LAT_A;
      end else if (e_rvalid != 2'b00 && ifa.resp_ready[m_owner]) begin
        m_owner = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input int p, input logic [2:0] op, input logic [31:0] a,
                         input logic [4:0] amt);
    if (p == 0) begin ifa.req_op0 = op; ifa.req_a0 = a; ifa.req_amt0 = amt; end
    else        begin ifa.req_op1 = op; ifa.req_a1 = a; ifa.req_amt1 = amt; end
    ifa.req_valid[p] = 1'b1;
  endtask

  task automatic a_wait_accept(input int p, input bit drop, output int unsigned acc_edge,
                               output logic [1:0] rdy_seen);
    int seen = 0;
    rdy_seen = 2'b00;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ifa.req_ready[p]) begin seen = 1; rdy_seen = ifa.req_ready; break; end
    end
    check_output($sformatf("accept p%0d seen", p), seen, 1);
    tick();
    acc_edge = edge_cnt;
    if (drop) ifa.req_valid[p] = 1'b0;
  endtask

  task automatic a_wait_resp(input int p, output logic [31:0] data, output int unsigned r_edge);
    int seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ifa.resp_valid[p]) begin seen = 1; break; end
    end
    check_output($sformatf("resp p%0d seen", p), seen, 1);
    data   = ifa.resp_data;
    r_edge = edge_cnt;
  endtask

  task automatic a_reset();
    tick();
    rst_a = 1'b0;
    ifa.req_valid = 2'b00;
    repeat (2) tick();
    rst_a = 1'b1;
  endtask

  task automatic apply_stimulus_a();
    int unsigned acc, rsp;
    logic [1:0]  rdy;
    logic [31:0] d, held;
    int seen, g;
    ifa.req_valid = 2'b00; ifa.resp_ready = 2'b11;
    ifa.req_op0 = '0; ifa.req_a0 = '0; ifa.req_amt0 = '0;
    ifa.req_op1 = '0; ifa.req_a1 = '0; ifa.req_amt1 = '0;
    repeat (3) tick();
    rst_a = 1'b1;
    tick();
    // Port 0 alone: left shift by 0 and by 5.
    a_drive(0, 3'b011, 32'hFFFFFFCA, 5'd0);
    a_wait_accept(0, 1'b1, acc, rdy);
    a_wait_resp(0, d, rsp);
    check_output("s1 amt0 data", d, 32'hFFFFFFCA);
    check_output("s1 amt0 latency", rsp - acc, 1);
    tick();
    a_drive(0, 3'b011, 32'hFFFFFFCA, 5'd5);
    a_wait_accept(0, 1'b1, acc, rdy);
    a_wait_resp(0, d, rsp);
    check_output("s1 amt5 data", d, 32'hFFFFF940);
    check_output("s1 amt5 latency", rsp - acc, 1);
    // Simultaneous requests from a fresh reset.
    a_reset();
    a_drive(0, 3'b100, 32'hFFFFFFCA, 5'd5);
    a_drive(1, 3'b101, 32'hFFFFFFCA, 5'd5);
    a_wait_accept(0, 1'b1, acc, rdy);
    check_output("s2 first tie ready", rdy, 2'b01);
    a_wait_resp(0, d, rsp);
    check_output("s2 port0 data", d, 32'h07FFFFFE);
    a_wait_accept(1, 1'b1, acc, rdy);
    check_output("s2 port1 ready", rdy, 2'b10);
    a_wait_resp(1, d, rsp);
    check_output("s2 port1 data", d, 32'hFFFFFFFE);
    // Continuous contention over six operations.
    tick();
    a_drive(0, 3'b011, 32'h11110000, 5'd1);
    a_drive(1, 3'b101, 32'hF0000000, 5'd4);
    for (int i = 0; i < 6; i++) begin
      seen = 0; g = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (ifa.req_ready != 2'b00) begin seen = 1; g = ifa.req_ready[1] ? 1 : 0; break; end
      end
      check_output("s3 grant seen", seen, 1);
      check_output($sformatf("s3 grant order %0d", i), g, i % 2);
      tick();
      if (g == 0) begin ifa.req_a0 += 32'h01010101; ifa.req_amt0 += 5'd3; end
      else        begin ifa.req_a1 += 32'h00100100; ifa.req_amt1 += 5'd2; end
    end
    ifa.req_valid = 2'b00;
    repeat (4) tick();
    // Back-pressure on port 1 while port 0 waits.
    ifa.resp_ready = 2'b01;
    a_drive(1, 3'b011, 32'h12345678, 5'd4);
    a_wait_accept(1, 1'b1, acc, rdy);
    a_drive(0, 3'b100, 32'hF0F0F0F0, 5'd8);
    a_wait_resp(1, held, rsp);
    check_output("s4 port1 data", held, 32'h23456780);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output("s4 hold resp_valid", ifa.resp_valid, 2'b10);
      check_output("s4 hold resp_data", ifa.resp_data, held);
      check_output("s4 hold req_ready", ifa.req_ready, 2'b00);
    end
    tick();
    ifa.resp_ready = 2'b11;
    a_wait_accept(0, 1'b1, acc, rdy);
    a_wait_resp(0, d, rsp);
    check_output("s4 port0 data", d, 32'h00F0F0F0);
    repeat (3) tick();
  endtask

  task automatic apply_stimulus_b();
    int seen;
    ifb.req_valid = 2'b00; ifb.resp_ready = 2'b11;
    ifb.req_op0 = 3'b011; ifb.req_a0 = 32'd3; ifb.req_amt0 = 5'd1;
    ifb.req_op1 = '0; ifb.req_a1 = '0; ifb.req_amt1 = '0;
    repeat (3) tick();
    rst_b = 1'b1;
    tick();
    ifb.req_valid = 2'b01;
    seen = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (ifb.req_ready[0]) begin seen = 1; break; end end
    check_output("b op1 accept seen", seen, 1);
    tick();
    ifb.req_valid = 2'b00;
    seen = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (ifb.resp_valid[0]) begin seen = 1; break; end end
    check_output("b op1 resp seen", seen, 1);
    check_output("b op1 data", ifb.resp_data, 32'd6);
    tick();
    ifb.req_a0 = 32'h000000F0; ifb.req_amt0 = 5'd2; ifb.req_valid = 2'b01;
    seen = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (ifb.req_ready[0]) begin seen = 1; break; end end
    check_output("b op2 accept seen", seen, 1);
    tick();
    ifb.req_valid = 2'b00;
    @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    check_output("b rst busy", busy_b, 0);
    check_output("b rst req_ready", ifb.req_ready, 0);
    check_output("b rst resp_valid", ifb.resp_valid, 0);
    check_output("b rst sh_op", ifb.sh_op, 0);
    check_output("b rst sh_a", ifb.sh_a, 0);
    check_output("b rst sh_amt", ifb.sh_amt, 0);
    check_output("b rst resp_data", ifb.resp_data, 0);
    ifb.req_a0 = 32'd1; ifb.req_amt0 = 5'd3;
    ifb.req_op1 = 3'b100; ifb.req_a1 = 32'h100; ifb.req_amt1 = 5'd4;
    ifb.req_valid = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(negedge clk);
    check_output("b tie after reset", ifb.req_ready, 2'b01);
    tick();
    ifb.req_valid = 2'b00;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check_output("b first accept busy", busy_b, 1);
        check_output("b first accept sh_a", ifb.sh_a, 32'd1);
      end
      check_output("b no early resp", ifb.resp_valid, 2'b00);
    end
    @(negedge clk);
    check_output("b resp after 4", ifb.resp_valid, 2'b01);
    check_output("b resp data", ifb.resp_data, 32'd8);
    repeat (3) tick();
  endtask

  task automatic apply_stimulus_c();
    int seen;
    int unsigned acc;
    ifc.req_valid = 2'b00; ifc.resp_ready = 2'b11;
    ifc.req_op0 = '0; ifc.req_a0 = '0; ifc.req_amt0 = '0;
    ifc.req_op1 = 3'b101; ifc.req_a1 = 32'h80000000; ifc.req_amt1 = 5'd31;
    repeat (3) tick();
    rst_c = 1'b1;
    tick();
    ifc.req_valid = 2'b10;
    seen = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (ifc.req_ready[1]) begin seen = 1; break; end end
    check_output("c accept seen", seen, 1);
    tick();
    acc = edge_cnt;
    ifc.req_valid = 2'b00;
    seen = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (ifc.resp_valid[1]) begin seen = 1; break; end end
    check_output("c resp seen", seen, 1);
    check_output("c latency", edge_cnt - acc, 3);
    check_output("c data", ifc.resp_data, 32'hFFFFFFFF);
    repeat (3) tick();
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #2;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    fork
      apply_stimulus_a();
      apply_stimulus_b();
      apply_stimulus_c();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
